alu_frame_ctrl: RTL and testbench

- Sequencing front-end that feeds the parameterizable combinational ALU and returns its result.
- Collects a three-word frame (operand A, operand B, opcode) from a byte-stream receiver (UART RX side), holds the operands on registered outputs wired to the ALU inputs, and captures the ALU output.
- Hands the result to a byte-stream transmitter with a start/busy handshake.
- Sits between the UART RX/TX pair and the ALU in the top-level.

---
 rtl/alu_frame_ctrl.sv | 104 ++++++++++
 tb/tb_alu_frame_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_frame_ctrl.sv
// Frame sequencer between a byte-stream RX/TX pair and a combinational ALU:
// collects A, B and opcode words, then hands the ALU result to the transmitter.
module alu_frame_ctrl #(
    parameter int unsigned NB_DATA = 8,
    parameter int unsigned NB_OP   = 6
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_valid,
    output logic [NB_DATA-1:0] o_data_a,
    output logic [NB_DATA-1:0] o_data_b,
    output logic [NB_OP-1:0]   o_op,
    input  logic [NB_DATA-1:0] i_alu_result,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    input  logic               i_tx_busy,
    output logic               o_overrun
);

    typedef enum logic [1:0] {
        StGetA,
        StGetB,
        StGetOp,
        StSend
    } state_e;

    state_e             state_q, state_d;
    logic [NB_DATA-1:0] data_a_q, data_a_d;
    logic [NB_DATA-1:0] data_b_q, data_b_d;
    logic [NB_OP-1:0]   op_q, op_d;
    logic [NB_DATA-1:0] tx_data_q, tx_data_d;
    logic               tx_start_q, tx_start_d;
    logic               overrun_q, overrun_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= StGetA;
            data_a_q   <= '0;
            data_b_q   <= '0;
            op_q       <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_a_q   <= data_a_d;
            data_b_q   <= data_b_d;
            op_q       <= op_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            overrun_q  <= overrun_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        data_a_d   = data_a_q;
        data_b_d   = data_b_q;
        op_d       = op_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        overrun_d  = 1'b0;

        case (state_q)
            StGetA: begin
                if (i_rx_valid) begin
                    data_a_d = i_rx_data;
                    state_d  = StGetB;
                end
            end
            StGetB: begin
                if (i_rx_valid) begin
                    data_b_d = i_rx_data;
                    state_d  = StGetOp;
                end
            end
            StGetOp: begin
                if (i_rx_valid) begin
                    op_d    = i_rx_data[NB_OP-1:0];
                    state_d = StSend;
                end
            end
            StSend: begin
                // Operands were registered a cycle ago, so the ALU output has settled here.
                overrun_d = i_rx_valid;
                if (!i_tx_busy) begin
                    tx_data_d  = i_alu_result;
                    tx_start_d = 1'b1;
                    state_d    = StGetA;
                end
            end
            default: state_d = StGetA;
        endcase
    end

    assign o_data_a   = data_a_q;
    assign o_data_b   = data_b_q;
    assign o_op       = op_q;
    assign o_tx_data  = tx_data_q;
    assign o_tx_start = tx_start_q;
    assign o_overrun  = overrun_q;

endmodule

// File: tb/tb_alu_frame_ctrl.sv
// Scoreboard bench for alu_frame_ctrl: stimulus pushes expected frames, a
// negedge monitor pops and compares on every o_tx_start.
module tb_alu_frame_ctrl;

    logic       clk;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] data_a;
    logic [7:0] data_b;
    logic [5:0] op;
    logic [7:0] alu_result;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic       overrun;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    logic busy_prev = 1'b0;
    int starts_seen  = 0;
    int starts_exp   = 0;
    int ov_seen      = 0;
    int ov_exp       = 0;
    logic [7:0] cur_tx = 8'h00;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [5:0] op;
        logic [7:0] res;
        int         start_cyc;
    } exp_t;

    exp_t q[$];

    alu_frame_ctrl #(
        .NB_DATA(8),
        .NB_OP  (6)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_rx_data   (rx_data),
        .i_rx_valid  (rx_valid),
        .o_data_a    (data_a),
        .o_data_b    (data_b),
        .o_op        (op),
        .i_alu_result(alu_result),
        .o_tx_data   (tx_data),
        .o_tx_start  (tx_start),
        .i_tx_busy   (tx_busy),
        .o_overrun   (overrun)
    );

    // Behavioural ALU: feeds the DUT and produces the expected results.
    function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                           input logic [5:0] o);
        logic signed [7:0] sa;
        sa = a;
        case (o)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            6'h03:   return sa >>> b;
            6'h02:   return a >> b;
            6'h27:   return ~(a | b);
            default: return 8'h00;
        endcase
    endfunction

    assign alu_result = alu_ref(data_a, data_b, op);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc       <= cyc + 1;
        busy_prev <= tx_busy;
    end

    // Monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (tx_start) begin
                starts_seen++;
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_start: got tx_data 0x%0h expected no start", tx_data);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("tx_data", 32'(tx_data), 32'(e.res));
                    chk("data_a", 32'(data_a), 32'(e.a));
                    chk("data_b", 32'(data_b), 32'(e.b));
                    chk("op", 32'(op), 32'(e.op));
                    chk("start_cycle", 32'(cyc), 32'(e.start_cyc));
                    chk("start_while_busy", 32'(busy_prev), 32'd0);
                    cur_tx = e.res;
                end
            end else begin
                chk("tx_hold", 32'(tx_data), 32'(cur_tx));
            end
            if (overrun) ov_seen++;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic put_word(input logic [7:0] w);
        rx_valid = 1'b1;
        rx_data  = w;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = $urandom_range(0, 255);
    endtask

    // ov_mode: 0 none, 1 one word mid-stall, 2 random words during stall.
    task automatic do_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opw,
                            input int stall, input int ov_mode, input bit ov_fall);
        exp_t e;
        e.a   = a;
        e.b   = b;
        e.op  = opw[5:0];
        e.res = alu_ref(a, b, opw[5:0]);
        put_word(a);
        idle($urandom_range(0, 2));
        put_word(b);
        idle($urandom_range(0, 2));
        if (stall > 0) tx_busy = 1'b1;
        put_word(opw);
        starts_exp++;
        if (stall == 0) begin
            e.start_cyc = cyc + 1;
            q.push_back(e);
        end else begin
            for (int i = 0; i < stall; i++) begin
                if ((ov_mode == 1 && i == stall / 2) ||
                    (ov_mode == 2 && $urandom_range(0, 2) == 0)) begin
                    rx_valid = 1'b1;
                    ov_exp++;
                end
                @(posedge clk);
                #1;
                rx_valid = 1'b0;
            end
            tx_busy     = 1'b0;
            e.start_cyc = cyc + 1;
            q.push_back(e);
            if (ov_fall) begin
                ov_exp++;
                put_word(8'hA5);
            end
        end
        idle(1 + $urandom_range(0, 1));
    endtask

    localparam logic [5:0] OPS [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h03, 6'h02, 6'h27};

    initial begin
        rst_n    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_busy  = 1'b0;
        #12;
        chk("rst_data_a", 32'(data_a), 32'd0);
        chk("rst_data_b", 32'(data_b), 32'd0);
        chk("rst_op", 32'(op), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_tx_start", 32'(tx_start), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_alu", 32'(alu_result), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        do_frame(8'h05, 8'h03, 8'h20, 0, 0, 1'b0);
        do_frame(8'h03, 8'h05, 8'h22, 0, 0, 1'b0);
        do_frame(8'h80, 8'h01, 8'h03, 0, 0, 1'b0);
        do_frame(8'h05, 8'h03, 8'h24, 10, 1, 1'b0);
        idle(2);
        chk("overrun_count", 32'(ov_seen), 32'(ov_exp));
        do_frame(8'h0F, 8'hF0, 8'h25, 0, 0, 1'b0);
        do_frame(8'h7F, 8'h01, 8'hE0, 0, 0, 1'b0);
        do_frame(8'h3C, 8'h0F, 8'h26, 3, 0, 1'b1);
        idle(2);
        chk("overrun_at_fall", 32'(ov_seen), 32'(ov_exp));

        // Reset in the middle of a frame
        put_word(8'h11);
        put_word(8'h22);
        #2;
        rst_n  = 1'b0;
        cur_tx = 8'h00;
        #1;
        chk("midrst_data_a", 32'(data_a), 32'd0);
        chk("midrst_data_b", 32'(data_b), 32'd0);
        chk("midrst_op", 32'(op), 32'd0);
        chk("midrst_tx_data", 32'(tx_data), 32'd0);
        chk("midrst_tx_start", 32'(tx_start), 32'd0);
        chk("midrst_overrun", 32'(overrun), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);
        do_frame(8'h02, 8'h02, 8'h27, 0, 0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            logic [7:0] ra, rb, ro;
            int         st;
            ra = $urandom_range(0, 255);
            rb = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 9)) : 8'($urandom_range(0, 255));
            ro = {2'($urandom_range(0, 3)), OPS[$urandom_range(0, 7)]};
            if ($urandom_range(0, 9) == 0) ro = 8'($urandom_range(0, 255));
            st = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0;
            do_frame(ra, rb, ro, st, (st > 0) ? 2 : 0, (st > 0) && ($urandom_range(0, 3) == 0));
        end

        idle(5);
        chk("queue_empty", 32'(q.size()), 32'd0);
        chk("start_count", 32'(starts_seen), 32'(starts_exp));
        chk("overrun_total", 32'(ov_seen), 32'(ov_exp));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
